jk_seq_monitor: RTL and testbench
=================================

Name: jk_seq_monitor

Overview:
- Downstream checker for the 3-bit JK-flip-flop counter. Samples the counter outputs {a,b,c} each enabled clock and compares every transition against the golden next-state function.
- Reports lock onto the steady loop, counts completed loops and counts illegal transitions.
- Feeds status and debug logic. Shares clk with the counter.

Parameters:
- ERR_W, 8, width of the saturating error counter.
- LOOP_W, 16, width of the wrapping loop counter.
- LOCK_N, 2, consecutive good in-loop transitions required before entering LOCKED (range 1..7).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  reset, synchronous, active-high
- enable  in  1  sample qualifier; when low, the block holds all state
- clear  in  1  synchronous clear of counters and FSM to IDLE
- a  in  1  counter bit 2 (MSB)
- b  in  1  counter bit 1
- c  in  1  counter bit 0
- locked  out  1  FSM is in LOCKED
- fault  out  1  FSM is in FAULT
- err_pulse  out  1  one-cycle pulse per detected mismatch
- err_count  out  ERR_W  saturating mismatch count
- loop_count  out  LOOP_W  completed loops while LOCKED, wraps modulo 2^LOOP_W
- state_onehot  out  8  registered one-hot decode of the last sample (bit index = {a,b,c})

Behaviour:
- Golden next-state NEXT(s), s={a,b,c}:
  - 000→011, 011→100, 100→111, 111→001, 001→010, 010→101, 101→111, 110→001.
  - Loop set L = {111,001,010,101}, period 4. All other states are transient.
- Reset values: FSM=IDLE, prev_valid=0, locked=0, fault=0, err_pulse=0, err_count=0, loop_count=0, state_onehot=0, good_run=0.
- All outputs are registered. Response appears the cycle after the sampling edge.
- enable=0: state, prev, counters and onehot are held; err_pulse=0.
- On an enabled sample cur:
  - state_onehot ← 1<<cur; prev ← cur; prev_valid ← 1.
  - mismatch = prev_valid && (cur != NEXT(prev)).
- FSM:
  - IDLE: first enabled sample loads prev with no check, then go to ACQUIRE.
  - ACQUIRE:
    - mismatch: err_pulse=1, err_count++, good_run←0.
    - good transition with cur∈L: good_run++. When good_run reaches LOCK_N, go to LOCKED and set good_run←0.
    - good transition with cur∉L: good_run unchanged.
  - LOCKED:
    - good transition 101→111: loop_count++.
    - mismatch: err_pulse=1, err_count++, go to FAULT.
  - FAULT: fault=1, locked=0. Keeps counting mismatches and keeps tracking prev. Exits only on clear or reset.
- err_count saturates at 2^ERR_W−1; err_pulse still fires at saturation. loop_count wraps to 0.
- clear=1: FSM←IDLE, prev_valid←0, good_run←0, err_count←0, loop_count←0, state_onehot←0. The sample in that cycle is discarded.
- Priority: reset > clear > enable.
- Reset or clear mid-lock: the next enabled sample is unchecked and restarts acquisition.
- Transient states (000, 011, 100, 110) are legal as a first sample and as legal transitions.

Optional Feature:
- JKSEQ_CAPTURE_EN.
- Defined: adds outputs cap_prev[3], cap_cur[3] and cap_valid.
  - The first mismatch since reset/clear latches {prev, cur} and sets cap_valid=1.
  - Later mismatches do not overwrite the capture.
  - clear or reset zeroes all three outputs.
- Undefined: these ports and registers are absent. All other behaviour is identical.

Decomposition:
- Package jkseq_pkg:
  - State constants S000..S111.
  - FSM enum {IDLE, ACQUIRE, LOCKED, FAULT}.
  - Loop-membership constant mask 8'b1010_0110 (bits 1, 2, 5, 7).
  - Golden next-state function.
- Sub-module jkseq_next_lut: pure combinational 3→3 golden table, reused by the bench scoreboard.

Test Plan:
- Reset, then enable with samples 000,011,100,111,001,010 (LOCK_N=2) → locked=1 one cycle after the 001 sample; err_count=0.
- Locked, then feed 101,111 five times → loop_count=5, err_pulse never asserted.
- Locked, then inject 111→010 → err_pulse=1 for one cycle, err_count=1, fault=1, locked=0. With CAPTURE_EN: cap_prev=111, cap_cur=010, cap_valid=1.
- ERR_W=2, in ACQUIRE drive 5 mismatches (000→000 repeated) → err_count sticks at 3; err_pulse pulses 5 times.
- FAULT, assert clear together with enable and sample 111 → next cycle IDLE, counters=0, state_onehot=0. The following sample is unchecked.
- Toggle enable low for 3 cycles mid-loop (outputs held), then resume with the correct next state → no mismatch, loop_count continues.

Source files
------------

// File: rtl/jkseq_pkg.sv
// rtl/jkseq_pkg.sv - shared constants, FSM encoding and golden next-state function for jk_seq_monitor
package jkseq_pkg;

  localparam logic [2:0] S000 = 3'b000;
  localparam logic [2:0] S001 = 3'b001;
  localparam logic [2:0] S010 = 3'b010;
  localparam logic [2:0] S011 = 3'b011;
  localparam logic [2:0] S100 = 3'b100;
  localparam logic [2:0] S101 = 3'b101;
  localparam logic [2:0] S110 = 3'b110;
  localparam logic [2:0] S111 = 3'b111;

  // Bit n set means counter state n belongs to the steady loop 111->001->010->101.
  localparam logic [7:0] LOOP_MASK = 8'b1010_0110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } fsm_e;

  function automatic logic [2:0] jk_next(input logic [2:0] s);
    case (s)
      S000: return S011;
      S001: return S010;
      S010: return S101;
      S011: return S100;
      S100: return S111;
      S101: return S111;
      S110: return S001;
      S111: return S001;
    endcase
  endfunction

endpackage

// File: rtl/jkseq_next_lut.sv
// rtl/jkseq_next_lut.sv - combinational golden next-state table of the 3-bit JK counter
module jkseq_next_lut
  import jkseq_pkg::*;
(
  input  logic [2:0] s_i,
  output logic [2:0] next_o
);

  assign next_o = jk_next(s_i);

endmodule

// File: rtl/jk_seq_monitor.sv
// rtl/jk_seq_monitor.sv - JK counter transition checker; JKSEQ_CAPTURE_EN adds first-mismatch capture ports
module jk_seq_monitor
  import jkseq_pkg::*;
#(
  parameter int ERR_W  = 8,
  parameter int LOOP_W = 16,
  parameter int LOCK_N = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              a,
  input  logic              b,
  input  logic              c,
  output logic              locked,
  output logic              fault,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [LOOP_W-1:0] loop_count,
  output logic [7:0]        state_onehot
`ifdef JKSEQ_CAPTURE_EN
  ,
  output logic [2:0]        cap_prev,
  output logic [2:0]        cap_cur,
  output logic              cap_valid
`endif
);

  localparam logic [2:0] LOCK_N_V = 3'(LOCK_N);

  fsm_e              state_q, state_d;
  logic [2:0]        prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [2:0]        good_run_q, good_run_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [LOOP_W-1:0] loop_count_q, loop_count_d;
  logic [7:0]        onehot_q, onehot_d;
  logic              err_pulse_q, err_pulse_d;
`ifdef JKSEQ_CAPTURE_EN
  logic [2:0]        cap_prev_q, cap_prev_d;
  logic [2:0]        cap_cur_q, cap_cur_d;
  logic              cap_valid_q, cap_valid_d;
`endif

  logic [2:0] cur;
  logic [2:0] exp_next;
  logic       mismatch;
  logic       in_loop;
  logic [2:0] good_run_inc;

  assign cur          = {a, b, c};
  assign mismatch     = prev_valid_q && (cur != exp_next);
  assign in_loop      = LOOP_MASK[cur];
  assign good_run_inc = good_run_q + 3'd1;

  jkseq_next_lut u_next_lut (
    .s_i    (prev_q),
    .next_o (exp_next)
  );

  // State register; clear is folded into the next-state logic so reset alone lives here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      prev_q       <= S000;
      prev_valid_q <= 1'b0;
      good_run_q   <= 3'd0;
      err_count_q  <= '0;
      loop_count_q <= '0;
      onehot_q     <= 8'd0;
      err_pulse_q  <= 1'b0;
`ifdef JKSEQ_CAPTURE_EN
      cap_prev_q   <= 3'd0;
      cap_cur_q    <= 3'd0;
      cap_valid_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      good_run_q   <= good_run_d;
      err_count_q  <= err_count_d;
      loop_count_q <= loop_count_d;
      onehot_q     <= onehot_d;
      err_pulse_q  <= err_pulse_d;
`ifdef JKSEQ_CAPTURE_EN
      cap_prev_q   <= cap_prev_d;
      cap_cur_q    <= cap_cur_d;
      cap_valid_q  <= cap_valid_d;
`endif
    end
  end

  // Next-state: clear discards the sample; otherwise each enabled sample is checked against prev.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    good_run_d   = good_run_q;
    err_count_d  = err_count_q;
    loop_count_d = loop_count_q;
    onehot_d     = onehot_q;
    err_pulse_d  = 1'b0;
`ifdef JKSEQ_CAPTURE_EN
    cap_prev_d   = cap_prev_q;
    cap_cur_d    = cap_cur_q;
    cap_valid_d  = cap_valid_q;
`endif

    if (clear) begin
      state_d      = IDLE;
      prev_valid_d = 1'b0;
      good_run_d   = 3'd0;
      err_count_d  = '0;
      loop_count_d = '0;
      onehot_d     = 8'd0;
`ifdef JKSEQ_CAPTURE_EN
      cap_prev_d   = 3'd0;
      cap_cur_d    = 3'd0;
      cap_valid_d  = 1'b0;
`endif
    end else if (enable) begin
      onehot_d     = 8'b1 << cur;
      prev_d       = cur;
      prev_valid_d = 1'b1;

      if (mismatch) begin
        err_pulse_d = 1'b1;
        if (err_count_q != {ERR_W{1'b1}}) begin
          err_count_d = err_count_q + 1'b1;
        end
`ifdef JKSEQ_CAPTURE_EN
        if (!cap_valid_q) begin
          cap_prev_d  = prev_q;
          cap_cur_d   = cur;
          cap_valid_d = 1'b1;
        end
`endif
      end

      case (state_q)
        IDLE: state_d = ACQUIRE;
        ACQUIRE: begin
          if (mismatch) begin
            good_run_d = 3'd0;
          end else if (in_loop) begin
            if (good_run_inc == LOCK_N_V) begin
              state_d    = LOCKED;
              good_run_d = 3'd0;
            end else begin
              good_run_d = good_run_inc;
            end
          end
        end
        LOCKED: begin
          if (mismatch) begin
            state_d = FAULT;
          end else if (prev_q == S101 && cur == S111) begin
            loop_count_d = loop_count_q + 1'b1;
          end
        end
        FAULT: state_d = FAULT;
      endcase
    end
  end

  assign locked       = (state_q == LOCKED);
  assign fault        = (state_q == FAULT);
  assign err_pulse    = err_pulse_q;
  assign err_count    = err_count_q;
  assign loop_count   = loop_count_q;
  assign state_onehot = onehot_q;
`ifdef JKSEQ_CAPTURE_EN
  assign cap_prev     = cap_prev_q;
  assign cap_cur      = cap_cur_q;
  assign cap_valid    = cap_valid_q;
`endif

endmodule

// File: tb/tb_jk_seq_monitor.sv
// tb/tb_jk_seq_monitor.sv - directed bench for jk_seq_monitor (default and ERR_W=2 instances)
module tb_jk_seq_monitor;

  logic        clk = 1'b0;
  logic        reset, enable, clear, a, b, c;

  logic        locked, fault, err_pulse;
  logic [7:0]  err_count;
  logic [15:0] loop_count;
  logic [7:0]  state_onehot;

  logic        s_locked, s_fault, s_err_pulse;
  logic [1:0]  s_err_count;
  logic [15:0] s_loop_count;
  logic [7:0]  s_state_onehot;

`ifdef JKSEQ_CAPTURE_EN
  logic [2:0]  cap_prev, cap_cur, s_cap_prev, s_cap_cur;
  logic        cap_valid, s_cap_valid;
`endif

  int n_vec  = 0;
  int n_err  = 0;
  int pulses = 0;
  int pulses_sat = 0;

  always #5 clk = ~clk;

  jk_seq_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .a            (a),
    .b            (b),
    .c            (c),
    .locked       (locked),
    .fault        (fault),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .loop_count   (loop_count),
    .state_onehot (state_onehot)
`ifdef JKSEQ_CAPTURE_EN
    ,
    .cap_prev     (cap_prev),
    .cap_cur      (cap_cur),
    .cap_valid    (cap_valid)
`endif
  );

  jk_seq_monitor #(.ERR_W(2), .LOOP_W(16), .LOCK_N(2)) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .a            (a),
    .b            (b),
    .c            (c),
    .locked       (s_locked),
    .fault        (s_fault),
    .err_pulse    (s_err_pulse),
    .err_count    (s_err_count),
    .loop_count   (s_loop_count),
    .state_onehot (s_state_onehot)
`ifdef JKSEQ_CAPTURE_EN
    ,
    .cap_prev     (s_cap_prev),
    .cap_cur      (s_cap_cur),
    .cap_valid    (s_cap_valid)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic clr, input logic [2:0] s);
    enable = en;
    clear  = clr;
    {a, b, c} = s;
    @(posedge clk);
    #1;
    if (err_pulse)   pulses++;
    if (s_err_pulse) pulses_sat++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; {a, b, c} = 3'b000;
    step(1'b0, 1'b0, 3'b000);
    step(1'b1, 1'b0, 3'b011);
    reset = 1'b0;

    chk("rst_locked",     32'(locked), 0);
    chk("rst_fault",      32'(fault), 0);
    chk("rst_err_pulse",  32'(err_pulse), 0);
    chk("rst_err_count",  32'(err_count), 0);
    chk("rst_loop_count", 32'(loop_count), 0);
    chk("rst_onehot",     32'(state_onehot), 0);
`ifdef JKSEQ_CAPTURE_EN
    chk("rst_cap_valid",  32'(cap_valid), 0);
`endif

    // Acquisition through transient states; lock after 111 and 001 in-loop.
    step(1'b1, 1'b0, 3'b000);
    chk("acq_onehot_000", 32'(state_onehot), 32'h01);
    step(1'b1, 1'b0, 3'b011);
    step(1'b1, 1'b0, 3'b100);
    step(1'b1, 1'b0, 3'b111);
    chk("acq_locked_111", 32'(locked), 0);
    chk("acq_onehot_111", 32'(state_onehot), 32'h80);
    step(1'b1, 1'b0, 3'b001);
    chk("lock_after_001", 32'(locked), 1);
    chk("lock_err_count", 32'(err_count), 0);
    step(1'b1, 1'b0, 3'b010);
    chk("lock_hold_010",  32'(locked), 1);

    // Five full loops, each closing on 101->111.
    pulses = 0;
    step(1'b1, 1'b0, 3'b101);
    step(1'b1, 1'b0, 3'b111);
    chk("loop_count_1",   32'(loop_count), 1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 3'b001);
      step(1'b1, 1'b0, 3'b010);
      step(1'b1, 1'b0, 3'b101);
      step(1'b1, 1'b0, 3'b111);
    end
    chk("loop_count_5",   32'(loop_count), 5);
    chk("loop_sat_5",     32'(s_loop_count), 5);
    chk("loop_no_pulse",  32'(pulses), 0);

    // Illegal 111->010 while locked.
    step(1'b1, 1'b0, 3'b010);
    chk("inj_err_pulse",  32'(err_pulse), 1);
    chk("inj_err_count",  32'(err_count), 1);
    chk("inj_fault",      32'(fault), 1);
    chk("inj_locked",     32'(locked), 0);
    chk("inj_loop_kept",  32'(loop_count), 5);
`ifdef JKSEQ_CAPTURE_EN
    chk("inj_cap_prev",   32'(cap_prev), 32'h7);
    chk("inj_cap_cur",    32'(cap_cur), 32'h2);
    chk("inj_cap_valid",  32'(cap_valid), 1);
`endif
    step(1'b0, 1'b0, 3'b110);
    chk("inj_pulse_one",  32'(err_pulse), 0);
    chk("hold_fault",     32'(fault), 1);

    // Second mismatch in FAULT: 010 -> 000 (expected 101).
    step(1'b1, 1'b0, 3'b000);
    chk("flt_err_pulse",  32'(err_pulse), 1);
    chk("flt_err_count",  32'(err_count), 2);
    chk("flt_sat_count",  32'(s_err_count), 2);
    chk("flt_stays",      32'(fault), 1);
`ifdef JKSEQ_CAPTURE_EN
    chk("flt_cap_cur",    32'(cap_cur), 32'h2);
`endif

    // Clear with enable and sample 111: sample discarded.
    step(1'b1, 1'b1, 3'b111);
    chk("clr_fault",      32'(fault), 0);
    chk("clr_locked",     32'(locked), 0);
    chk("clr_err_count",  32'(err_count), 0);
    chk("clr_loop_count", 32'(loop_count), 0);
    chk("clr_onehot",     32'(state_onehot), 0);
    chk("clr_err_pulse",  32'(err_pulse), 0);
`ifdef JKSEQ_CAPTURE_EN
    chk("clr_cap_valid",  32'(cap_valid), 0);
`endif
    step(1'b1, 1'b0, 3'b000);
    chk("post_clr_nochk", 32'(err_pulse), 0);
    chk("post_clr_oneh",  32'(state_onehot), 32'h01);

    // Five 000->000 mismatches in ACQUIRE; ERR_W=2 saturates at 3.
    pulses = 0; pulses_sat = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3'b000);
    chk("sat_err_count",  32'(s_err_count), 3);
    chk("sat_pulses",     32'(pulses_sat), 5);
    chk("wide_err_count", 32'(err_count), 5);
    chk("wide_pulses",    32'(pulses), 5);
    chk("sat_not_locked", 32'(s_locked), 0);

    // Relock, then hold enable low mid-loop.
    step(1'b0, 1'b1, 3'b000);
    step(1'b1, 1'b0, 3'b111);
    step(1'b1, 1'b0, 3'b001);
    chk("relock_early",   32'(locked), 0);
    step(1'b1, 1'b0, 3'b010);
    chk("relock",         32'(locked), 1);
    step(1'b1, 1'b0, 3'b101);
    step(1'b1, 1'b0, 3'b111);
    step(1'b1, 1'b0, 3'b001);
    chk("pre_hold_loop",  32'(loop_count), 1);
    pulses = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'b110);
    chk("hold_onehot",    32'(state_onehot), 32'h02);
    chk("hold_locked",    32'(locked), 1);
    chk("hold_loop",      32'(loop_count), 1);
    step(1'b1, 1'b0, 3'b010);
    chk("resume_onehot",  32'(state_onehot), 32'h04);
    step(1'b1, 1'b0, 3'b101);
    step(1'b1, 1'b0, 3'b111);
    chk("resume_loop",    32'(loop_count), 2);
    chk("resume_pulses",  32'(pulses), 0);
    chk("resume_errcnt",  32'(err_count), 0);

    // Reset mid-lock: first sample (transient 110) unchecked, then relock.
    reset = 1'b1;
    step(1'b1, 1'b0, 3'b011);
    reset = 1'b0;
    chk("mid_rst_locked", 32'(locked), 0);
    chk("mid_rst_loop",   32'(loop_count), 0);
    step(1'b1, 1'b0, 3'b110);
    chk("mid_rst_nochk",  32'(err_pulse), 0);
    step(1'b1, 1'b0, 3'b001);
    chk("mid_rst_good",   32'(err_pulse), 0);
    chk("mid_rst_acq",    32'(locked), 0);
    step(1'b1, 1'b0, 3'b010);
    chk("mid_rst_relock", 32'(locked), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
